// File: rtl/mac_tile_ws_os.sv
// Systolic MAC processing element supporting weight-stationary (mode=0) and
// output-stationary (mode=1) dataflows; every east/south output is registered.
module mac_tile_ws_os #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int SAT     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [1:0]         inst_w,
  input  logic [bw-1:0]      in_w,
  input  logic [psum_bw-1:0] in_n,
  output logic [bw-1:0]      out_e,
  output logic [1:0]         inst_e,
  output logic [psum_bw-1:0] out_s
);

  localparam logic [1:0] INST_NOP   = 2'b00;
  localparam logic [1:0] INST_LOAD  = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;
  localparam logic [1:0] INST_DRAIN = 2'b11;

  logic [bw-1:0]      w_q;
  logic               loaded_q;
  logic [psum_bw-1:0] acc_q;
  logic [bw-1:0]      out_e_q;
  logic [1:0]         inst_e_q;
  logic [psum_bw-1:0] out_s_q;
  logic               mode_q;

  // One multiplier/adder serves both modes: WS uses the stored weight and the
  // north psum, OS uses the north weight and the local accumulator.
  logic [bw-1:0]             wt;
  logic [psum_bw-1:0]        addend;
  logic signed [2*bw:0]      a_ext, w_ext, prod;
  logic signed [psum_bw:0]   prod_ext, add_ext, sum;
  logic [psum_bw-1:0]        f_sum;
  logic [psum_bw-1:0]        wt_sext;

  always_comb begin
    wt       = mode_q ? in_n[bw-1:0] : w_q;
    addend   = mode_q ? acc_q : in_n;
    a_ext    = {{(bw+1){1'b0}}, in_w};
    w_ext    = {{(bw+1){wt[bw-1]}}, wt};
    prod     = a_ext * w_ext;
    prod_ext = {{(psum_bw-2*bw){prod[2*bw]}}, prod};
    add_ext  = {addend[psum_bw-1], addend};
    sum      = prod_ext + add_ext;
    wt_sext  = {{(psum_bw-bw){in_n[bw-1]}}, in_n[bw-1:0]};
    // Overflow of the signed result shows as disagreement of the top two bits.
    if (SAT != 0 && sum[psum_bw] != sum[psum_bw-1]) begin
      f_sum = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      f_sum = sum[psum_bw-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q      <= '0;
      loaded_q <= 1'b0;
      acc_q    <= '0;
      out_e_q  <= '0;
      inst_e_q <= INST_NOP;
      out_s_q  <= '0;
      mode_q   <= mode;
    end else if (mode != mode_q) begin
      // Mode change wipes local state and behaves as a nop for this cycle.
      w_q      <= '0;
      loaded_q <= 1'b0;
      acc_q    <= '0;
      inst_e_q <= INST_NOP;
      out_s_q  <= '0;
      mode_q   <= mode;
    end else begin
      if (inst_w != INST_NOP) out_e_q <= in_w;
      inst_e_q <= inst_w;
      out_s_q  <= '0;
      case (inst_w)
        INST_LOAD: begin
          if (!mode_q) begin
            if (!loaded_q) begin
              w_q      <= in_w;
              loaded_q <= 1'b1;
              inst_e_q <= INST_NOP;
            end
          end else begin
            acc_q <= '0;
          end
        end
        INST_EXEC: begin
          if (!mode_q) begin
            out_s_q <= f_sum;
          end else begin
            acc_q   <= f_sum;
            out_s_q <= wt_sext;
          end
        end
        INST_DRAIN: begin
          if (mode_q) begin
            out_s_q <= acc_q;
            acc_q   <= in_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_e  = out_e_q;
  assign inst_e = inst_e_q;
  assign out_s  = out_s_q;

endmodule
